// File: rtl/pbs_hp_arbiter.sv
// HP register owner for player/AI Pokemon: arbitrates two update requesters onto one
// shared add/sub unit, sequencing each update as read/compute/write, and flags dead Pokemon.
module pbs_hp_arbiter #(
    parameter int unsigned HP_W   = 8,
    parameter int unsigned MAX_HP = 100
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            init,
    input  logic            req0_valid,
    input  logic            req0_target,
    input  logic            req0_op,
    input  logic [HP_W-1:0] req0_amt,
    input  logic            req1_valid,
    input  logic            req1_target,
    input  logic            req1_op,
    input  logic [HP_W-1:0] req1_amt,
    output logic            req0_ack,
    output logic            req1_ack,
    output logic            busy,
    output logic            done,
    output logic            done_id,
    output logic [HP_W-1:0] p_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic            p_dead,
    output logic            ai_dead
);

    localparam logic [HP_W-1:0] MAX_V   = HP_W'(MAX_HP);
    localparam logic [HP_W:0]   MAX_EXT = (HP_W+1)'(MAX_HP);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CALC, S_WRITE} state_t;

    state_t          state_q, state_d;
    logic            tgt_q, tgt_d, op_q, op_d, id_q, id_d;
    logic [HP_W-1:0] amt_q, amt_d, operand_q, operand_d, result_q, result_d;
    logic            last_grant_q, last_grant_d;
    logic [HP_W-1:0] p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
    logic            p_dead_q, p_dead_d, ai_dead_q, ai_dead_d;
    logic            ack0_q, ack0_d, ack1_q, ack1_d;
    logic            done_q, done_d, done_id_q, done_id_d, busy_q, busy_d;
    logic            gnt;
    logic [HP_W:0]   sum;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tgt_q        <= 1'b0;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            amt_q        <= '0;
            operand_q    <= '0;
            result_q     <= '0;
            last_grant_q <= 1'b1;
            p_hp_q       <= MAX_V;
            ai_hp_q      <= MAX_V;
            p_dead_q     <= 1'b0;
            ai_dead_q    <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            op_q         <= op_d;
            id_q         <= id_d;
            amt_q        <= amt_d;
            operand_q    <= operand_d;
            result_q     <= result_d;
            last_grant_q <= last_grant_d;
            p_hp_q       <= p_hp_d;
            ai_hp_q      <= ai_hp_d;
            p_dead_q     <= p_dead_d;
            ai_dead_q    <= ai_dead_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        op_d         = op_q;
        id_d         = id_q;
        amt_d        = amt_q;
        operand_d    = operand_q;
        result_d     = result_q;
        last_grant_d = last_grant_q;
        p_hp_d       = p_hp_q;
        ai_hp_d      = ai_hp_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        gnt          = 1'b0;
        sum          = {1'b0, operand_q} + {1'b0, amt_q};

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie, alternate away from the previous winner
                    gnt          = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    id_d         = gnt;
                    tgt_d        = gnt ? req1_target : req0_target;
                    op_d         = gnt ? req1_op     : req0_op;
                    amt_d        = gnt ? req1_amt    : req0_amt;
                    last_grant_d = gnt;
                    ack0_d       = ~gnt;
                    ack1_d       = gnt;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                operand_d = tgt_q ? ai_hp_q : p_hp_q;
                state_d   = S_CALC;
            end
            S_CALC: begin
                if (op_q) begin
                    result_d = (sum > MAX_EXT) ? MAX_V : sum[HP_W-1:0];
                end else begin
                    result_d = (amt_q >= operand_q) ? '0 : operand_q - amt_q;
                end
                done_d    = 1'b1;
                done_id_d = id_q;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                // Battle is frozen once either side is dead
                if (!(p_dead_q || ai_dead_q)) begin
                    if (tgt_q) ai_hp_d = result_q;
                    else       p_hp_d  = result_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (init) begin
            state_d = S_IDLE;
            p_hp_d  = MAX_V;
            ai_hp_d = MAX_V;
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            done_d  = 1'b0;
        end

        p_dead_d  = (p_hp_d == '0);
        ai_dead_d = (ai_hp_d == '0);
        busy_d    = (state_d != S_IDLE);
    end

    assign req0_ack = ack0_q;
    assign req1_ack = ack1_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign p_hp     = p_hp_q;
    assign ai_hp    = ai_hp_q;
    assign p_dead   = p_dead_q;
    assign ai_dead  = ai_dead_q;

endmodule

// File: tb/tb_pbs_hp_arbiter.sv
// Scoreboard bench for pbs_hp_arbiter: directed ops push expected acks/dones with cycle stamps;
// a negedge monitor pops and compares ids, timing and the HP/dead state after each write.
module tb_pbs_hp_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       init = 1'b0;
    logic       req0_valid = 1'b0, req0_target = 1'b0, req0_op = 1'b0;
    logic [7:0] req0_amt = '0;
    logic       req1_valid = 1'b0, req1_target = 1'b0, req1_op = 1'b0;
    logic [7:0] req1_amt = '0;
    logic       req0_ack, req1_ack, busy, done, done_id, p_dead, ai_dead;
    logic [7:0] p_hp, ai_hp;

    pbs_hp_arbiter #(.HP_W(8), .MAX_HP(100)) dut (
        .clk(clk), .reset_n(reset_n), .init(init),
        .req0_valid(req0_valid), .req0_target(req0_target), .req0_op(req0_op), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_target(req1_target), .req1_op(req1_op), .req1_amt(req1_amt),
        .req0_ack(req0_ack), .req1_ack(req1_ack), .busy(busy), .done(done), .done_id(done_id),
        .p_hp(p_hp), .ai_hp(ai_hp), .p_dead(p_dead), .ai_dead(ai_dead)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit id;
        int cyc;
    } ack_t;

    typedef struct {
        bit id;
        int cyc;
        int p;
        int ai;
        bit pd;
        bit aid;
    } done_t;

    ack_t  ackq[$];
    done_t doneq[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every ack/done the DUT presents against the queued expectations
    initial begin
        ack_t  a;
        done_t d, hp_exp;
        bit    hp_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (hp_pend) begin
                    chk("p_hp_after_write", int'(p_hp), hp_exp.p);
                    chk("ai_hp_after_write", int'(ai_hp), hp_exp.ai);
                    chk("p_dead_after_write", int'(p_dead), int'(hp_exp.pd));
                    chk("ai_dead_after_write", int'(ai_dead), int'(hp_exp.aid));
                    hp_pend = 1'b0;
                end
                if (req0_ack || req1_ack) begin
                    chk("ack_onehot", int'(req0_ack & req1_ack), 0);
                    if (ackq.size() == 0) begin
                        chk("ack_unexpected", 1, 0);
                    end else begin
                        a = ackq.pop_front();
                        chk("ack_id", int'(req1_ack), int'(a.id));
                        chk("ack_cycle", cyc, a.cyc);
                    end
                end
                if (done) begin
                    if (doneq.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        d = doneq.pop_front();
                        chk("done_id", int'(done_id), int'(d.id));
                        chk("done_cycle", cyc, d.cyc);
                        hp_exp  = d;
                        hp_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic drive_req(input bit id, input bit v, input bit tgt, input bit op, input logic [7:0] amt);
        if (id) begin
            req1_valid = v; req1_target = tgt; req1_op = op; req1_amt = amt;
        end else begin
            req0_valid = v; req0_target = tgt; req0_op = op; req0_amt = amt;
        end
    endtask

    task automatic issue(input bit id, input bit tgt, input bit op, input logic [7:0] amt,
                         input int ep, input int eai, input bit epd, input bit eaid);
        int  c;
        bit  got;
        ack_t  a;
        done_t d;
        @(posedge clk); #1;
        drive_req(id, 1'b1, tgt, op, amt);
        c = cyc;
        a.id = id; a.cyc = c + 1;
        ackq.push_back(a);
        d.id = id; d.cyc = c + 3; d.p = ep; d.ai = eai; d.pd = epd; d.aid = eaid;
        doneq.push_back(d);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if ((id ? req1_ack : req0_ack) == 1'b1) got = 1'b1;
        end
        if (!got) chk("ack_timeout", 0, 1);
        @(posedge clk); #1;
        drive_req(id, 1'b0, tgt, op, amt);
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_init();
        @(posedge clk); #1;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        chk("init_busy", int'(busy), 0);
        chk("init_p_hp", int'(p_hp), 100);
        chk("init_ai_hp", int'(ai_hp), 100);
        chk("init_p_dead", int'(p_dead), 0);
        chk("init_ai_dead", int'(ai_dead), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_p_hp", int'(p_hp), 100);
        chk("rst_ai_hp", int'(ai_hp), 100);
        chk("rst_p_dead", int'(p_dead), 0);
        chk("rst_ai_dead", int'(ai_dead), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_acks", int'(req0_ack | req1_ack), 0);
        chk("rst_done", int'(done), 0);
    endtask

    initial begin
        int    c;
        ack_t  a;
        done_t d;

        do_reset();

        // Single damage op with exact latency
        issue(1'b0, 1'b1, 1'b0, 8'd30, 100, 70, 1'b0, 1'b0);

        // Overkill kills the AI, then a heal is acked but frozen
        issue(1'b1, 1'b1, 1'b0, 8'd120, 100, 0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 1'b1, 8'd50, 100, 0, 1'b0, 1'b1);
        pulse_init();

        // Heal clamp, zero amount, exact kill
        issue(1'b1, 1'b0, 1'b0, 8'd20, 80, 100, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 8'd50, 100, 100, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 8'd0, 100, 100, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 8'd90, 10, 100, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 1'b0, 8'd10, 0, 100, 1'b1, 1'b0);

        // init during S_CALC drops the op: acked, never done
        pulse_init();
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 8'd30);
        c = cyc;
        a.id = 1'b0; a.cyc = c + 1;
        ackq.push_back(a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 8'd30);
        chk("calc_busy", int'(busy), 1);
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        chk("drop_busy", int'(busy), 0);
        chk("drop_done", int'(done), 0);
        chk("drop_p_hp", int'(p_hp), 100);
        chk("drop_ai_hp", int'(ai_hp), 100);
        chk("drop_p_dead", int'(p_dead), 0);
        repeat (4) @(posedge clk);
        chk("drop_p_hp_later", int'(p_hp), 100);

        // Fresh reset so the first tie goes to requester 0; both held for 16 cycles
        do_reset();
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        drive_req(1'b1, 1'b1, 1'b1, 1'b0, 8'd7);
        c = cyc;
        a.id = 1'b0; a.cyc = c + 1;  ackq.push_back(a);
        a.id = 1'b1; a.cyc = c + 5;  ackq.push_back(a);
        a.id = 1'b0; a.cyc = c + 9;  ackq.push_back(a);
        a.id = 1'b1; a.cyc = c + 13; ackq.push_back(a);
        d.pd = 1'b0; d.aid = 1'b0;
        d.id = 1'b0; d.cyc = c + 3;  d.p = 95; d.ai = 100; doneq.push_back(d);
        d.id = 1'b1; d.cyc = c + 7;  d.p = 95; d.ai = 93;  doneq.push_back(d);
        d.id = 1'b0; d.cyc = c + 11; d.p = 90; d.ai = 93;  doneq.push_back(d);
        d.id = 1'b1; d.cyc = c + 15; d.p = 90; d.ai = 86;  doneq.push_back(d);
        repeat (16) @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        drive_req(1'b1, 1'b0, 1'b1, 1'b0, 8'd7);
        repeat (8) @(posedge clk);

        chk("ack_queue_drained", ackq.size(), 0);
        chk("done_queue_drained", doneq.size(), 0);
        chk("final_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
